// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one variable-latency memory bus between the fetch (I)
// and load/store (D) ports; data has fixed priority. Optional MEMARB_TIMEOUT_EN
// bounds the wait for a bus response and adds the bus_err_o port.
// Revision: 1.0
// ============================================================================
module mem_arbiter #(
    parameter int XLEN = 32
`ifdef MEMARB_TIMEOUT_EN
    , parameter int TIMEOUT = 64
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic [XLEN-1:0] if_rdata_o,
    output logic            if_valid_o,
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [3:0]      d_wstrb_i,
    input  logic [XLEN-1:0] d_addr_i,
    input  logic [XLEN-1:0] d_wdata_i,
    output logic [XLEN-1:0] d_rdata_o,
    output logic            d_valid_o,
    output logic            m_req_o,
    output logic            m_we_o,
    output logic [3:0]      m_wstrb_o,
    output logic [XLEN-1:0] m_addr_o,
    output logic [XLEN-1:0] m_wdata_o,
    input  logic            m_ready_i,
    input  logic            m_rvalid_i,
    input  logic [XLEN-1:0] m_rdata_i,
`ifdef MEMARB_TIMEOUT_EN
    output logic            bus_err_o,
`endif
    output logic            stall_f_o,
    output logic            stall_m_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;      // 1 = data port owns the bus
    logic              discard_q, discard_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [3:0]        m_wstrb_q, m_wstrb_d;
    logic [XLEN-1:0]   m_addr_q, m_addr_d;
    logic [XLEN-1:0]   m_wdata_q, m_wdata_d;
    logic [XLEN-1:0]   if_rdata_q, if_rdata_d;
    logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              d_valid_q, d_valid_d;
    logic              resp_go;
    logic [XLEN-1:0]   resp_data;
`ifdef MEMARB_TIMEOUT_EN
    localparam logic [XLEN-1:0] NOP_INSN = XLEN'(32'h0000_0013);
    logic [7:0]        cnt_q, cnt_d;
    logic              bus_err_q, bus_err_d;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        discard_d  = discard_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_wstrb_d  = m_wstrb_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        resp_go    = 1'b0;
        resp_data  = m_rdata_i;
`ifdef MEMARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        bus_err_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                discard_d = 1'b0;
                if (d_req_i) begin
                    owner_d   = 1'b1;
                    m_we_d    = d_we_i;
                    m_wstrb_d = d_wstrb_i;
                    m_addr_d  = d_addr_i;
                    m_wdata_d = d_wdata_i;
                    m_req_d   = 1'b1;
                    state_d   = S_ISSUE;
                end else if (if_req_i) begin
                    owner_d   = 1'b0;
                    m_we_d    = 1'b0;
                    m_wstrb_d = 4'b0000;
                    m_addr_d  = if_addr_i;
                    m_req_d   = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!owner_q && !if_req_i) discard_d = 1'b1;
                if (m_ready_i) begin
                    m_req_d = 1'b0;
`ifdef MEMARB_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                    if (m_rvalid_i) begin
                        resp_go = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!owner_q && !if_req_i) discard_d = 1'b1;
`ifdef MEMARB_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                if (m_rvalid_i) begin
                    resp_go = 1'b1;
                    state_d = S_RESP;
                end
`ifdef MEMARB_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    // Substitute a harmless value so the pipeline can proceed.
                    resp_go   = 1'b1;
                    resp_data = owner_q ? '0 : NOP_INSN;
                    bus_err_d = 1'b1;
                    state_d   = S_RESP;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Valid pulses are registered so they coincide with the RESP cycle.
        if (resp_go) begin
            if (owner_q) begin
                d_valid_d = 1'b1;
                if (!m_we_q) d_rdata_d = resp_data;
            end else if (!discard_d) begin
                if_valid_d = 1'b1;
                if_rdata_d = resp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            discard_q  <= 1'b0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_wstrb_q  <= 4'b0000;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
`ifdef MEMARB_TIMEOUT_EN
            cnt_q      <= 8'd0;
            bus_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            discard_q  <= discard_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_wstrb_q  <= m_wstrb_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
`ifdef MEMARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            bus_err_q  <= bus_err_d;
`endif
        end
    end

    assign if_rdata_o = if_rdata_q;
    assign if_valid_o = if_valid_q;
    assign d_rdata_o  = d_rdata_q;
    assign d_valid_o  = d_valid_q;
    assign m_req_o    = m_req_q;
    assign m_we_o     = m_we_q;
    assign m_wstrb_o  = m_wstrb_q;
    assign m_addr_o   = m_addr_q;
    assign m_wdata_o  = m_wdata_q;
`ifdef MEMARB_TIMEOUT_EN
    assign bus_err_o  = bus_err_q;
`endif
    // Stalls are forced low while reset is held so every output reads zero.
    assign stall_f_o  = rst_n & if_req_i & ~if_valid_q;
    assign stall_m_o  = rst_n & d_req_i & ~d_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : self-checking bench for mem_arbiter (vector table plus
// hand-written flush/contention/reset/timeout sequences, bus scoreboard).
// Revision: 1.0
// ============================================================================
module tb_mem_arbiter;
    localparam int XLEN = 32;
    localparam int MAXW = 100;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_req_i, d_req_i, d_we_i, m_ready_i, m_rvalid_i;
    logic [XLEN-1:0] if_addr_i, d_addr_i, d_wdata_i, m_rdata_i;
    logic [3:0]      d_wstrb_i;
    logic [XLEN-1:0] if_rdata_o, d_rdata_o, m_addr_o, m_wdata_o;
    logic            if_valid_o, d_valid_o, m_req_o, m_we_o, stall_f_o, stall_m_o;
    logic [3:0]      m_wstrb_o;
`ifdef MEMARB_TIMEOUT_EN
    logic            bus_err_o;
`endif

    mem_arbiter #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_rdata_o (if_rdata_o),
        .if_valid_o (if_valid_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_wstrb_i  (d_wstrb_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_rdata_o  (d_rdata_o),
        .d_valid_o  (d_valid_o),
        .m_req_o    (m_req_o),
        .m_we_o     (m_we_o),
        .m_wstrb_o  (m_wstrb_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_ready_i  (m_ready_i),
        .m_rvalid_i (m_rvalid_i),
        .m_rdata_i  (m_rdata_i),
`ifdef MEMARB_TIMEOUT_EN
        .bus_err_o  (bus_err_o),
`endif
        .stall_f_o  (stall_f_o),
        .stall_m_o  (stall_m_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [XLEN-1:0] addr;
        logic            we;
        logic [3:0]      wstrb;
        logic [XLEN-1:0] wdata;
    } bus_t;

    typedef struct {
        bit              is_d;
        bit              we;
        logic [3:0]      wstrb;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [XLEN-1:0] rdata;
        int              rdy;
        int              rv;
        int              lat;
        logic [XLEN-1:0] exp_rdata;
    } vec_t;

    bus_t sb[$];
    vec_t vecs[7];
    vec_t v;
    bus_t e;
    bit   ok;
    int   t0;
    int   nchk = 0;
    int   nfail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic wait_mreq(output bit okv);
        int n = 0;
        while (m_req_o !== 1'b1 && n < MAXW) begin
            @(negedge clk);
            n++;
        end
        okv = (m_req_o === 1'b1);
        if (!okv) chk("m_req_timeout", m_req_o, 1);
    endtask

    task automatic pop_check(output bus_t ex);
        if (sb.size() == 0) begin
            nchk++;
            nfail++;
            $display("FAIL sb_underflow: got bus request addr %h expected none", m_addr_o);
            ex = '{m_addr_o, 1'b0, 4'h0, '0};
        end else begin
            ex = sb.pop_front();
            chk("m_addr", m_addr_o, ex.addr);
            chk("m_we", m_we_o, ex.we);
            chk("m_wstrb", m_wstrb_o, ex.wstrb);
            if (ex.we) chk("m_wdata", m_wdata_o, ex.wdata);
        end
    endtask

    task automatic bus_serve(input int rdy, input int rv, input logic [XLEN-1:0] rd);
        bit   okv;
        bus_t ex;
        wait_mreq(okv);
        if (!okv) return;
        pop_check(ex);
        for (int i = 0; i < rdy; i++) begin
            @(negedge clk);
            chk("hold_m_req", m_req_o, 1);
            chk("hold_m_addr", m_addr_o, ex.addr);
        end
        m_ready_i  = 1'b1;
        m_rvalid_i = (rv == 0);
        m_rdata_i  = rd;
        @(negedge clk);
        m_ready_i  = 1'b0;
        m_rvalid_i = 1'b0;
        chk("m_req_drop", m_req_o, 0);
        if (rv > 0) begin
            repeat (rv - 1) @(negedge clk);
            m_rvalid_i = 1'b1;
            m_rdata_i  = rd;
            @(negedge clk);
            m_rvalid_i = 1'b0;
        end
    endtask

    task automatic wait_valid(input bit is_d, output bit okv);
        int n = 0;
        while ((is_d ? d_valid_o : if_valid_o) !== 1'b1 && n < MAXW) begin
            @(negedge clk);
            n++;
        end
        okv = ((is_d ? d_valid_o : if_valid_o) === 1'b1);
        if (!okv) chk(is_d ? "d_valid_timeout" : "if_valid_timeout", is_d ? d_valid_o : if_valid_o, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            is_d  we    wstrb  addr          wdata         rdata         rdy rv lat exp_rdata
        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,        32'h0050_0093, 0, 2, 4, 32'h0050_0093};
        vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_2000, 32'h0,        32'h1122_3344, 0, 1, 3, 32'h1122_3344};
        vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h0000_2004, 32'hCAFE_BABE, 32'hDEAD_BEEF, 1, 3, 6, 32'h1122_3344};
        vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h0000_0104, 32'h0,        32'h00A0_0113, 0, 0, 2, 32'h00A0_0113};
        vecs[4] = '{1'b1, 1'b0, 4'hF, 32'h0000_2008, 32'h0,        32'hA5A5_A5A5, 2, 0, 4, 32'hA5A5_A5A5};
        vecs[5] = '{1'b0, 1'b0, 4'h0, 32'h0000_0108, 32'h0,        32'h0020_81B3, 5, 1, 8, 32'h0020_81B3};
        vecs[6] = '{1'b1, 1'b1, 4'hF, 32'h0000_200C, 32'h0BAD_F00D, 32'h1234_5678, 0, 2, 4, 32'hA5A5_A5A5};

        rst_n = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_wstrb_i = 4'h0; d_addr_i = '0; d_wdata_i = '0;
        m_ready_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_m_req", m_req_o, 0);
        chk("rst_m_addr", m_addr_o, 0);
        chk("rst_valids", {30'h0, if_valid_o, d_valid_o}, 0);
        chk("rst_rdata", if_rdata_o | d_rdata_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            v  = vecs[k];
            t0 = cyc;
            if (v.is_d) begin
                d_req_i = 1'b1; d_we_i = v.we; d_wstrb_i = v.wstrb;
                d_addr_i = v.addr; d_wdata_i = v.wdata;
            end else begin
                if_req_i = 1'b1; if_addr_i = v.addr;
            end
            sb.push_back('{v.addr, v.is_d & v.we, v.is_d ? v.wstrb : 4'h0, v.wdata});
            #1;
            chk("stall_assert", v.is_d ? stall_m_o : stall_f_o, 1);
            bus_serve(v.rdy, v.rv, v.rdata);
            wait_valid(v.is_d, ok);
            if (ok) begin
                chk("latency", cyc - t0, v.lat);
                chk(v.is_d ? "d_rdata" : "if_rdata", v.is_d ? d_rdata_o : if_rdata_o, v.exp_rdata);
                chk("stall_release", v.is_d ? stall_m_o : stall_f_o, 0);
                chk("other_valid", v.is_d ? if_valid_o : d_valid_o, 0);
            end
            if_req_i = 1'b0;
            d_req_i  = 1'b0;
            @(negedge clk);
            chk("pulse_once", {30'h0, if_valid_o, d_valid_o}, 0);
            chk("idle_m_req", m_req_o, 0);
        end

        // Contention: data must be served first, fetch stalled throughout.
        if_req_i = 1'b1; if_addr_i = 32'h0000_0180;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_2000;
        sb.push_back('{32'h0000_2000, 1'b0, d_wstrb_i, d_wdata_i});
        sb.push_back('{32'h0000_0180, 1'b0, 4'h0, '0});
        bus_serve(0, 1, 32'h55AA_55AA);
        wait_valid(1'b1, ok);
        chk("cont_d_rdata", d_rdata_o, 32'h55AA_55AA);
        chk("cont_stall_f", stall_f_o, 1);
        chk("cont_no_if_valid", if_valid_o, 0);
        d_req_i = 1'b0;
        @(negedge clk);
        chk("cont_stall_f_gap", stall_f_o, 1);
        bus_serve(0, 1, 32'h00C0_0193);
        wait_valid(1'b0, ok);
        chk("cont_if_rdata", if_rdata_o, 32'h00C0_0193);
        if_req_i = 1'b0;
        @(negedge clk);

        // Fetch withdrawn while waiting: its completion must be dropped.
        if_req_i = 1'b1; if_addr_i = 32'h0000_0200;
        sb.push_back('{32'h0000_0200, 1'b0, 4'h0, '0});
        wait_mreq(ok);
        pop_check(e);
        m_ready_i = 1'b1;
        @(negedge clk);
        m_ready_i = 1'b0;
        if_req_i  = 1'b0;
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h0000_0300;
        sb.push_back('{32'h0000_0300, 1'b0, 4'h0, '0});
        m_rvalid_i = 1'b1; m_rdata_i = 32'hBAD0_0000;
        @(negedge clk);
        m_rvalid_i = 1'b0;
        chk("flush_no_valid", if_valid_o, 0);
        chk("flush_stall_f", stall_f_o, 1);
        bus_serve(0, 1, 32'h0010_0073);
        wait_valid(1'b0, ok);
        chk("flush_if_rdata", if_rdata_o, 32'h0010_0073);
        if_req_i = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of a WAIT.
        if_req_i = 1'b1; if_addr_i = 32'h0000_0400;
        sb.push_back('{32'h0000_0400, 1'b0, 4'h0, '0});
        wait_mreq(ok);
        pop_check(e);
        m_ready_i = 1'b1;
        @(negedge clk);
        m_ready_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_m_addr", m_addr_o, 0);
        chk("arst_m_wdata", m_wdata_o, 0);
        chk("arst_if_rdata", if_rdata_o, 0);
        chk("arst_d_rdata", d_rdata_o, 0);
        chk("arst_ctrl", {25'h0, m_req_o, m_we_o, m_wstrb_o, if_valid_o, d_valid_o}, 0);
        chk("arst_stalls", {30'h0, stall_f_o, stall_m_o}, 0);
`ifdef MEMARB_TIMEOUT_EN
        chk("arst_bus_err", bus_err_o, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{32'h0000_0400, 1'b0, 4'h0, '0});
        bus_serve(0, 1, 32'h0000_0517);
        wait_valid(1'b0, ok);
        chk("post_rst_if_rdata", if_rdata_o, 32'h0000_0517);
        if_req_i = 1'b0;
        @(negedge clk);

`ifdef MEMARB_TIMEOUT_EN
        // No response at all: forced completion with a NOP.
        if_req_i = 1'b1; if_addr_i = 32'h0000_0500;
        sb.push_back('{32'h0000_0500, 1'b0, 4'h0, '0});
        wait_mreq(ok);
        pop_check(e);
        m_ready_i = 1'b1;
        @(negedge clk);
        m_ready_i = 1'b0;
        wait_valid(1'b0, ok);
        chk("to_bus_err", bus_err_o, 1);
        chk("to_if_rdata", if_rdata_o, 32'h0000_0013);
        if_req_i = 1'b0;
        @(negedge clk);
        chk("to_bus_err_pulse", bus_err_o, 0);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, variable-latency memory bus between the instruction-fetch port (IF) and the load/store port (MEM).
- Sits between the pipelined datapath and a unified instruction/data memory.
- Drives stall requests into the hazard unit while a requester waits.
- One outstanding bus transaction at a time. Bus outputs are registered.

Parameters:
XLEN, 32, data/address width
TIMEOUT, 64, max cycles in WAIT before forced completion (only with MEMARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held until if_valid or withdrawn
if_addr  in  XLEN  fetch address
if_rdata  out  XLEN  fetched instruction
if_valid  out  1  one-cycle fetch completion pulse
d_req  in  1  data request; held until d_valid
d_we  in  1  1 = store, 0 = load
d_wstrb  in  4  byte write enables (MemWriteSelect)
d_addr  in  XLEN  data address
d_wdata  in  XLEN  store data
d_rdata  out  XLEN  load data
d_valid  out  1  one-cycle data completion pulse
m_req  out  1  bus request
m_we  out  1  bus write
m_wstrb  out  4  bus byte strobes
m_addr  out  XLEN  bus address
m_wdata  out  XLEN  bus write data
m_ready  in  1  bus accepts request this cycle
m_rvalid  in  1  bus completion (reads and writes)
m_rdata  in  XLEN  bus read data
stall_f  out  1  stall fetch stage
stall_m  out  1  stall memory stage

Behaviour:
- Reset (reset low, async): state IDLE. All outputs 0, including m_* registers, rdata registers, valid pulses and owner flag.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If d_req: grant data; latch d_we/d_wstrb/d_addr/d_wdata into m_* registers; owner=D; go to ISSUE.
  - Else if if_req: grant fetch; m_we=0, m_wstrb=0, m_addr=if_addr; owner=I; go to ISSUE.
  - Data has fixed priority: the older instruction wins.
- ISSUE: m_req=1, m_* stable. When m_ready=1: m_req drops next cycle; go to WAIT. If m_ready and m_rvalid are both 1 in the same cycle, go directly to RESP.
- WAIT: on m_rvalid, capture m_rdata into owner's rdata register; go to RESP.
- RESP:
  - Owner's valid=1 for exactly this cycle; go to IDLE.
  - Requests are not sampled in RESP. A requester still high is re-arbitrated in IDLE next cycle.
  - Minimum transaction: 3 cycles from grant to valid (ISSUE, RESP, plus one cycle for the IDLE grant).
- Fetch withdrawal (branch flush):
  - If if_req is low in any cycle of an owner=I transaction after grant, set a discard flag.
  - The transaction still completes on the bus, but if_valid is suppressed in RESP.
  - Flag clears in IDLE.
- Data requests are never withdrawn. Withdrawing a data request is illegal; the arbiter ignores it and still pulses d_valid.
- Stores: d_rdata is not updated. d_valid still pulses.
- stall_f = if_req & ~if_valid.
- stall_m = d_req & ~d_valid.
- Both stalls are combinational from registered state.
- Simultaneous if_req and d_req in IDLE: data served first; fetch served in the following IDLE. stall_f stays high throughout.
- if_rdata/d_rdata hold their last captured value until overwritten.

Optional Feature:
MEMARB_TIMEOUT_EN
- With the macro:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without m_rvalid: capture 32'h0000_0013 (NOP) for fetch or 32'h0 for loads; go to RESP; pulse output port bus_err (1 bit, reset 0) for one cycle together with valid.
  - A late m_rvalid arriving in IDLE is ignored.
- Without the macro: no counter and no bus_err port; WAIT is unbounded.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100; bus ready immediately, rvalid 2 cycles later with 0x00500093 -> m_addr=0x100, m_we=0; if_valid one cycle with if_rdata=0x00500093; stall_f high until that cycle.
- Contention: if_req and d_req (load, 0x2000) rise together -> data transaction issued first, d_valid before any fetch m_req. Next m_req carries the fetch address. stall_f stays high throughout.
- Store: d_we=1, d_wstrb=4'b0011, d_addr=0x2004, d_wdata=0xCAFEBABE -> m_we=1, m_wstrb=0011, m_wdata=0xCAFEBABE; d_valid pulses; d_rdata unchanged.
- Flush: fetch 0x200 granted, if_req dropped in WAIT, then raised with 0x300 -> no if_valid for 0x200; next bus request m_addr=0x300, completes normally.
- m_ready held low 5 cycles in ISSUE -> m_req and m_addr stable all 5 cycles; single transaction.
- Reset low asserted mid-WAIT -> all outputs 0 immediately (async). After release, FSM in IDLE and accepts a new fetch. With MEMARB_TIMEOUT_EN: no m_rvalid for 64 cycles -> bus_err and if_valid pulse together, if_rdata=0x00000013.
